// File: rtl/div_op_sequencer_if.sv
// Handshake bundle for the divider operand sequencer:
// operand input, divider side-band and result output.
interface div_op_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_dividend;
    logic [3:0] in_divisor;

    logic       div_start;
    logic [3:0] div_dividend;
    logic [3:0] div_divisor;
    logic [3:0] div_quotient;
    logic [3:0] div_remainder;
    logic       div_done;

    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_quotient;
    logic [3:0] out_remainder;
    logic       out_dbz;
    logic       out_timeout;

    modport slave (
        input  in_valid, in_dividend, in_divisor,
        input  div_quotient, div_remainder, div_done,
        input  out_ready,
        output in_ready, div_start,
        output div_dividend, div_divisor,
        output out_valid, out_quotient, out_remainder,
        output out_dbz, out_timeout
    );

    modport master (
        output in_valid, in_dividend, in_divisor,
        output div_quotient, div_remainder, div_done,
        output out_ready,
        input  in_ready, div_start,
        input  div_dividend, div_divisor,
        input  out_valid, out_quotient, out_remainder,
        input  out_dbz, out_timeout
    );
endinterface

// File: rtl/div_op_sequencer.sv
// Operand FIFO and issue/wait/result sequencer in front of the
// 4-bit sequential divider, with divide-by-zero bypass and watchdog.
module div_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               rst,
    div_op_sequencer_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESULT
    } state_t;

    state_t state_q, state_d;

    logic [3:0]    mem_a_q [FIFO_DEPTH];
    logic [3:0]    mem_b_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    logic [3:0] wd_q, wd_d;
    logic       start_q, start_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;
    logic       to_q, to_d;

    logic       push, pop, empty;
    logic [3:0] head_a, head_b;

    assign bus.in_ready = (cnt_q < (AW+1)'(FIFO_DEPTH));
    assign empty        = (cnt_q == '0);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state_q == RESULT) && bus.out_ready;

    // Head is only retired on the result handshake, so the divider
    // sees stable operands for the whole operation.
    assign head_a           = mem_a_q[rptr_q];
    assign head_b           = mem_b_q[rptr_q];
    assign bus.div_dividend = head_a;
    assign bus.div_divisor  = head_b;

    assign bus.div_start     = start_q;
    assign bus.out_valid     = (state_q == RESULT);
    assign bus.out_quotient  = quo_q;
    assign bus.out_remainder = rem_q;
    assign bus.out_dbz       = dbz_q;
    assign bus.out_timeout   = to_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wptr_q] <= bus.in_dividend;
            mem_b_q[wptr_q] <= bus.in_divisor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        wd_d    = wd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head_b != 4'd0) begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                    end else begin
                        state_d = RESULT;
                        quo_d   = 4'hF;
                        rem_d   = head_a;
                        dbz_d   = 1'b1;
                        to_d    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                // A done arriving on the expiry cycle still wins.
                if (bus.div_done) begin
                    state_d = RESULT;
                    quo_d   = bus.div_quotient;
                    rem_d   = bus.div_remainder;
                    dbz_d   = 1'b0;
                    to_d    = 1'b0;
                end else if (wd_q == 4'(TIMEOUT - 1)) begin
                    state_d = RESULT;
                    quo_d   = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    to_d    = 1'b1;
                end
            end
            RESULT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            wd_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            wd_q    <= wd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            to_q    <= to_d;
        end
    end
endmodule
